// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB master: command/response ports, programmable SCL divider, split SDA tristate
module sccb_master #(
  parameter int unsigned CLK_DIV        = 50,
  parameter int unsigned SUB_ADDR_BYTES = 1,
  parameter logic [6:0]  DEV_ID         = 7'h21,
  parameter bit          ACK_CHECK      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [8*SUB_ADDR_BYTES-1:0] cmd_addr,
  input  logic [7:0]                  cmd_wdata,
  output logic                        rsp_valid,
  output logic [7:0]                  rsp_rdata,
  output logic                        ack_err,
  output logic                        busy,
  output logic                        scl,
  output logic                        sda_o,
  output logic                        sda_oe,
  input  logic                        sda_i
);

  localparam int unsigned   FW       = 8 * SUB_ADDR_BYTES + 16;
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [2:0]    BYTES_WR = 3'(SUB_ADDR_BYTES + 1);
  localparam logic [2:0]    BYTES_RD = 3'(SUB_ADDR_BYTES);

  typedef enum logic [2:0] {
    IDLE, START, TX_BYTE, DC_BIT, RX_BYTE, NA_BIT, STOP, GAP
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          write_q, write_d;
  logic          second_q, second_d;
  logic [FW-1:0] tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          acc_q, acc_d;
  logic          rsp_q, rsp_d;
  logic          err_q, err_d;
  logic          scl_q, scl_d;
  logic          sdo_q, sdo_d;
  logic          soe_q, soe_d;

  logic tick, sample, unit_end;

  assign tick     = (div_q == DIV_LAST);
  assign sample   = tick && (qtr_q == 2'd2);
  assign unit_end = tick && (qtr_q == 2'd3);

  // Pad values for a given state/quarter: {scl, sda_o, sda_oe}.
  function automatic logic [2:0] bus_drive(input state_e st, input logic [1:0] q, input logic txb);
    logic pulse;
    pulse = (q == 2'd1) || (q == 2'd2);
    case (st)
      START:           bus_drive = {q != 2'd3, q < 2'd2, 1'b1};
      TX_BYTE:         bus_drive = {pulse, txb, 1'b1};
      DC_BIT, RX_BYTE: bus_drive = {pulse, 1'b1, 1'b0};
      NA_BIT:          bus_drive = {pulse, 1'b1, 1'b1};
      STOP:            bus_drive = {q != 2'd0, q >= 2'd2, 1'b1};
      default:         bus_drive = 3'b111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      qtr_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      write_q  <= 1'b0;
      second_q <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      acc_q    <= 1'b0;
      rsp_q    <= 1'b0;
      err_q    <= 1'b0;
      scl_q    <= 1'b1;
      sdo_q    <= 1'b1;
      soe_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      write_q  <= write_d;
      second_q <= second_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      acc_q    <= acc_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
      scl_q    <= scl_d;
      sdo_q    <= sdo_d;
      soe_q    <= soe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    write_d  = write_q;
    second_d = second_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    acc_d    = acc_q;
    rsp_d    = 1'b0;
    err_d    = 1'b0;

    if (state_q == IDLE) begin
      if (cmd_valid && cmd_ready) begin
        state_d  = START;
        div_d    = '0;
        qtr_d    = '0;
        bit_d    = '0;
        write_d  = cmd_write;
        second_d = 1'b0;
        byte_d   = cmd_write ? BYTES_WR : BYTES_RD;
        tx_d     = {DEV_ID, 1'b0, cmd_addr, cmd_wdata};
        acc_d    = 1'b0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
      case (state_q)
        START: if (unit_end) state_d = TX_BYTE;
        TX_BYTE: begin
          if (unit_end) begin
            tx_d  = tx_q << 1;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = DC_BIT;
          end
        end
        DC_BIT: begin
          if (sample && ACK_CHECK && sda_i) acc_d = 1'b1;
          if (unit_end) begin
            // byte_q counts bytes still to send after the one just acknowledged
            if (second_q) begin
              state_d = RX_BYTE;
            end else if (byte_q != 3'd0) begin
              state_d = TX_BYTE;
              byte_d  = byte_q - 3'd1;
            end else begin
              state_d = STOP;
            end
          end
        end
        RX_BYTE: begin
          if (sample) rx_d = {rx_q[6:0], sda_i};
          if (unit_end) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = NA_BIT;
          end
        end
        NA_BIT: if (unit_end) state_d = STOP;
        STOP: begin
          if (unit_end) begin
            if (write_q || second_q) begin
              state_d = IDLE;
              rsp_d   = 1'b1;
              err_d   = acc_q;
              if (!write_q) rdata_d = rx_q;
            end else begin
              state_d = GAP;
            end
          end
        end
        GAP: begin
          if (unit_end) begin
            state_d  = START;
            second_d = 1'b1;
            tx_d     = {DEV_ID, 1'b1, {(FW-8){1'b0}}};
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pads are registered from the next state so they stay aligned with state_q.
    {scl_d, sdo_d, soe_d} = bus_drive(state_d, qtr_d, tx_d[FW-1]);
  end

  assign cmd_ready = (state_q == IDLE) && !rsp_q;
  assign busy      = !cmd_ready;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign ack_err   = err_q;
  assign scl       = scl_q;
  assign sda_o     = sdo_q;
  assign sda_oe    = soe_q;

endmodule
